// File: rtl/btn_conditioner.sv
// btn_conditioner: four-button input conditioner.
// Synchronizes bouncing push-button levels, samples them on a prescaled
// tick, debounces each button independently, and emits one tick-period-wide
// press event per accepted press.
module btn_conditioner #(
    parameter int PRS_DIV  = 50000,
    parameter int DB_TICKS = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] btn_raw,
    output logic       tick,
    output logic [3:0] btn_de,
    output logic [3:0] btn_level
);

    localparam logic [19:0] PRS_LAST = 20'(PRS_DIV - 1);
    localparam logic [7:0]  DB_LAST  = 8'(DB_TICKS - 1);

    logic [19:0] prs_cnt;
    logic [3:0]  sync_p0;
    logic [3:0]  sync_p1;
    logic [7:0]  dbcnt [4];
    logic [3:0]  accept;

    // Prescaler: free-running 0..PRS_DIV-1, restarted by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            prs_cnt <= '0;
        end else if (prs_cnt == PRS_LAST) begin
            prs_cnt <= '0;
        end else begin
            prs_cnt <= prs_cnt + 20'd1;
        end
    end

    // Tick is decoded from the counter, so it is low whenever the counter is cleared.
    always_comb begin
        tick = (prs_cnt == PRS_LAST);
    end

    // Two-flop synchronizer; sync_p1 is the sample s[i] seen by the debouncer.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= btn_raw;
            sync_p1 <= sync_p0;
        end
    end

    // A button is accepted when it still differs on the tick that completes qualification.
    always_comb begin
        accept = '0;
        for (int i = 0; i < 4; i++) begin
            accept[i] = (sync_p1[i] != btn_level[i]) && (dbcnt[i] == DB_LAST);
        end
    end

    // Debounce state advances only on ticks; press events last one full tick period.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                dbcnt[i] <= '0;
            end
            btn_level <= '0;
            btn_de    <= '0;
        end else if (tick) begin
            for (int i = 0; i < 4; i++) begin
                if (sync_p1[i] == btn_level[i]) begin
                    dbcnt[i] <= '0;
                end else if (accept[i]) begin
                    btn_level[i] <= sync_p1[i];
                    dbcnt[i]     <= '0;
                end else begin
                    dbcnt[i] <= dbcnt[i] + 8'd1;
                end
            end
            btn_de <= accept & sync_p1;
        end
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// tb_btn_conditioner: directed bench for btn_conditioner with PRS_DIV=4,
// DB_TICKS=3. Expected press events are queued as stimulus is applied and a
// monitor pops them as btn_de rises.
module tb_btn_conditioner;

    localparam int PRS = 4;

    logic       clk;
    logic       reset;
    logic [3:0] btn_raw;
    logic       tick;
    logic [3:0] btn_de;
    logic [3:0] btn_level;

    typedef struct {
        int         cyc;
        logic [3:0] de;
        logic [3:0] lvl;
    } ev_t;

    ev_t exp_q[$];

    int n_tests  = 0;
    int n_failed = 0;
    int cyc      = 0;
    int origin   = 1;
    bit started  = 0;

    btn_conditioner #(
        .PRS_DIV (PRS),
        .DB_TICKS(3)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_raw  (btn_raw),
        .tick     (tick),
        .btn_de   (btn_de),
        .btn_level(btn_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_failed++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Advance to cycle n; inputs change 1 time unit after each rising edge.
    task automatic step_to(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    // Monitor: tick phase every cycle, press events against the queue, event width.
    logic [3:0] prev_de = '0;
    int         rise_cyc = 0;
    always @(negedge clk) begin
        if (started) begin
            chk("tick", {31'd0, tick}, {31'd0, ((cyc - origin) % PRS) == PRS - 1});
            if (btn_de !== prev_de) begin
                if (prev_de != 4'b0000) begin
                    chk("de_width", cyc - rise_cyc, PRS);
                end
                if (btn_de != 4'b0000) begin
                    rise_cyc = cyc;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_event", {28'd0, btn_de}, 32'd0);
                    end else begin
                        ev_t e;
                        e = exp_q.pop_front();
                        chk("event_cycle", cyc, e.cyc);
                        chk("event_de", {28'd0, btn_de}, {28'd0, e.de});
                        chk("event_level", {28'd0, btn_level}, {28'd0, e.lvl});
                    end
                end
            end
            prev_de = btn_de;
        end
    end

    initial begin
        reset   = 1'b1;
        btn_raw = 4'b0000;
        repeat (3) @(posedge clk);
        #1;
        reset   = 1'b0;
        cyc     = 1;
        origin  = 1;
        started = 1;

        // Reset state, then button 1 rises cleanly in cycle 1.
        chk("rst_de", {28'd0, btn_de}, 32'd0);
        chk("rst_level", {28'd0, btn_level}, 32'd0);
        chk("rst_tick", {31'd0, tick}, 32'd0);
        btn_raw[1] = 1'b1;
        exp_q.push_back('{13, 4'b0010, 4'b0010});
        step_to(12);
        chk("level_before_accept", {28'd0, btn_level}, 32'd0);
        step_to(13);
        chk("level_b1_accept", {28'd0, btn_level}, 32'h2);

        // Button 2 bounces: high for two ticks, low for one, then steady.
        step_to(17);
        btn_raw[2] = 1'b1;
        step_to(25);
        btn_raw[2] = 1'b0;
        step_to(29);
        btn_raw[2] = 1'b1;
        exp_q.push_back('{41, 4'b0100, 4'b0110});

        // Buttons 0 and 3 rise together.
        step_to(45);
        btn_raw[0] = 1'b1;
        btn_raw[3] = 1'b1;
        exp_q.push_back('{57, 4'b1001, 4'b1111});

        // Button 3 held 40 cycles then released: level drops, no event.
        step_to(85);
        btn_raw[3] = 1'b0;
        step_to(96);
        chk("level_b3_held", {28'd0, btn_level}, 32'hf);
        step_to(97);
        chk("level_b3_released", {28'd0, btn_level}, 32'h7);

        // Release buttons 0..2, then press button 1 again.
        btn_raw[2:0] = 3'b000;
        step_to(109);
        chk("level_all_released", {28'd0, btn_level}, 32'h0);
        btn_raw[1] = 1'b1;

        // Reset pulse while button 1 has one qualifying tick counted.
        step_to(113);
        reset = 1'b1;
        step_to(114);
        reset  = 1'b0;
        origin = 114;
        chk("midrst_de", {28'd0, btn_de}, 32'd0);
        chk("midrst_level", {28'd0, btn_level}, 32'd0);
        chk("midrst_tick", {31'd0, tick}, 32'd0);
        exp_q.push_back('{126, 4'b0010, 4'b0010});

        step_to(135);
        chk("events_outstanding", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

endmodule

// File: doc/btn_conditioner.md
BTN_CONDITIONER -- requirements
Module: btn_conditioner

Interface
REQ-001 Parameter PRS_DIV, default 50000, sets the clk cycles per sample tick (range 2..2^20).
REQ-002 Parameter DB_TICKS, default 16, sets the consecutive differing ticks needed to accept a level change (range 1..255).
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 reset  input  1  reset; synchronous and active-high.
REQ-005 btn_raw  input  4  asynchronous, bouncing push-button levels, 1 = pressed.
REQ-006 tick  output  1  one-clk-wide sample strobe, once per PRS_DIV cycles; the strobe for the control FSM's clk_prs domain.
REQ-007 btn_de  output  4  debounced press events; bit i is high for exactly one tick period per accepted press of button i.
REQ-008 btn_level  output  4  debounced button levels.

Function
REQ-009 Each btn_raw bit SHALL pass through a 2-flop synchronizer; the second flop output is sample s[i].
REQ-010 The prescaler counter SHALL count 0..PRS_DIV-1 and wrap to 0.
REQ-011 tick SHALL be 1 exactly in the cycles where the prescaler equals PRS_DIV-1.
REQ-012 The first tick after reset release SHALL occur in the PRS_DIV-th cycle.
REQ-013 Debounce counters, btn_level and btn_de SHALL update only in cycles with tick=1; they hold otherwise.
REQ-014 Per button on a tick, if s[i]==btn_level[i], dbcnt[i] SHALL clear to 0.
REQ-015 Per button on a tick, if s[i]!=btn_level[i] and dbcnt[i]<DB_TICKS-1, dbcnt[i] SHALL increment.
REQ-016 Per button on a tick, if s[i]!=btn_level[i] and dbcnt[i]==DB_TICKS-1 (accept), btn_level[i] SHALL take s[i] and dbcnt[i] SHALL clear.
REQ-017 On every tick, btn_de[i] SHALL be set to (accept[i] AND s[i]==1); release acceptances produce no event.
REQ-018 Consequently btn_de[i] SHALL rise one cycle after the accepting tick and stay high until one cycle after the next tick (PRS_DIV cycles), so a consumer clocked per tick sees it exactly once.
REQ-019 A bounce (s[i] returning to btn_level[i]) before acceptance SHALL clear dbcnt[i], restarting the qualification.
REQ-020 Buttons SHALL be independent; simultaneous accepts assert multiple btn_de bits in the same tick period, with no priority applied.
REQ-021 A held button SHALL generate one event only; a new event requires an accepted release, then an accepted press.
REQ-022 With DB_TICKS=1, a change SHALL be accepted on the first tick where it is sampled.
REQ-023 The debounce counters SHALL be 8 bits wide and SHALL never exceed DB_TICKS-1.

Reset
REQ-024 While reset=1, the following SHALL be cleared to 0 on the next clk edge: prescaler, synchronizers, dbcnt, btn_level, btn_de and tick.
REQ-025 Reset SHALL take priority over tick in the same cycle.
REQ-026 Reset mid-qualification SHALL discard partial counts and pending events.
REQ-027 A button held through reset release SHALL be re-qualified from level 0 and SHALL produce one event after DB_TICKS ticks.

Verification (PRS_DIV=4, DB_TICKS=3)
REQ-028 After reset release, with btn_raw=0 -> tick high at cycles 4, 8, 12, ...; btn_de=0 and btn_level=0 throughout.
REQ-029 btn_raw[1] rises clean at cycle 1 -> s[1]=1 from cycle 3; accepted on ticks 4, 8, 12; btn_de=4'b0010 over cycles 13..16; btn_level[1]=1 from cycle 13; btn_de=0 at cycle 17.
REQ-030 btn_raw[2] bounces 1 at ticks 4 and 8, 0 at tick 12, then steady 1 -> no event until three further consecutive ticks; exactly one btn_de[2] pulse results.
REQ-031 btn_raw[0] and btn_raw[3] rise together -> btn_de=4'b1001 for one tick period.
REQ-032 Button 3 held for 40 cycles, then released -> exactly one btn_de[3] pulse; btn_level[3] returns to 0 after 3 ticks of release; no pulse on release.
REQ-033 reset pulsed for 1 cycle while dbcnt[1]==1 with button 1 still held -> all outputs 0; btn_de[1] fires after 3 new ticks.
